cam_capture: RTL and testbench

- Receive-side counterpart of the VGA output path: accepts an 8-bit parallel camera stream (VSYNC/HREF framing, two bytes per pixel) and assembles 16-bit RGB565 pixels.
- Writes each pixel to the frame buffer with a linear pixel address, the same addressing the VGA reader uses (0 .. WIDTH_IMAGE*HEIGHT_IMAGE-1).
- Runs entirely in the camera pixel-clock domain; the frame buffer provides the clock-domain crossing.

---
 rtl/cam_capture.sv | 178 +++++++++++++++++
 tb/tb_cam_capture.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture.sv
// Camera capture: assembles 8-bit VSYNC/HREF byte pairs into RGB565 pixels
// and writes them to the frame buffer at linear pixel addresses.
module cam_capture #(
    parameter int unsigned WIDTH_IMAGE  = 640,
    parameter int unsigned HEIGHT_IMAGE = 480
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_capture_en,
    input  logic        i_vsync,
    input  logic        i_href,
    input  logic [7:0]  i_data,
    output logic        o_wr_en,
    output logic [18:0] o_wr_addr,
    output logic [15:0] o_wr_data,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_frame_ok,
    output logic [7:0]  o_frame_count
);

    localparam int unsigned NUM_PIXELS = WIDTH_IMAGE * HEIGHT_IMAGE;
    localparam int unsigned ADDR_W     = 19;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned CNT_W      = 8;
    // Counters saturate one past their nominal value so over-long lines/frames never alias.
    localparam int unsigned PIX_W      = $clog2(WIDTH_IMAGE + 2);
    localparam int unsigned LINE_W     = $clog2(HEIGHT_IMAGE + 2);

    typedef enum logic [1:0] {
        S_SYNC,
        S_WAIT,
        S_ACTIVE
    } state_t;

    state_t              state, state_nxt;
    logic                r_vsync, r_href, d_vsync, d_href;
    logic [BYTE_W-1:0]   r_data;
    logic                phase, phase_nxt;
    logic [BYTE_W-1:0]   hi_byte, hi_byte_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [PIX_W-1:0]    pix_cnt, pix_cnt_nxt;
    logic [LINE_W-1:0]   line_cnt, line_cnt_nxt;
    logic                line_err, line_err_nxt;
    logic                ovf, ovf_nxt;
    logic                wr_en_nxt;
    logic [ADDR_W-1:0]   wr_addr_nxt;
    logic [DATA_W-1:0]   wr_data_nxt;
    logic                busy_nxt, frame_done_nxt, frame_ok_nxt;
    logic [CNT_W-1:0]    frame_count_nxt;

    // HREF is only meaningful outside vertical blanking.
    logic href_v, vsync_rise, vsync_fall, href_fall;
    assign href_v     = r_href & ~r_vsync;
    assign vsync_rise = r_vsync & ~d_vsync;
    assign vsync_fall = ~r_vsync & d_vsync;
    assign href_fall  = d_href & ~href_v;

    // Input sampling and edge-detect delay stage.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vsync <= 1'b0;
            r_href  <= 1'b0;
            r_data  <= '0;
            d_vsync <= 1'b0;
            d_href  <= 1'b0;
        end else begin
            r_vsync <= i_vsync;
            r_href  <= i_href;
            r_data  <= i_data;
            d_vsync <= r_vsync;
            d_href  <= href_v;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= S_SYNC;
            phase         <= 1'b0;
            hi_byte       <= '0;
            addr          <= '0;
            pix_cnt       <= '0;
            line_cnt      <= '0;
            line_err      <= 1'b0;
            ovf           <= 1'b0;
            o_wr_en       <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_busy        <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_ok    <= 1'b0;
            o_frame_count <= '0;
        end else begin
            state         <= state_nxt;
            phase         <= phase_nxt;
            hi_byte       <= hi_byte_nxt;
            addr          <= addr_nxt;
            pix_cnt       <= pix_cnt_nxt;
            line_cnt      <= line_cnt_nxt;
            line_err      <= line_err_nxt;
            ovf           <= ovf_nxt;
            o_wr_en       <= wr_en_nxt;
            o_wr_addr     <= wr_addr_nxt;
            o_wr_data     <= wr_data_nxt;
            o_busy        <= busy_nxt;
            o_frame_done  <= frame_done_nxt;
            o_frame_ok    <= frame_ok_nxt;
            o_frame_count <= frame_count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        phase_nxt       = phase;
        hi_byte_nxt     = hi_byte;
        addr_nxt        = addr;
        pix_cnt_nxt     = pix_cnt;
        line_cnt_nxt    = line_cnt;
        line_err_nxt    = line_err;
        ovf_nxt         = ovf;
        wr_en_nxt       = 1'b0;
        wr_addr_nxt     = o_wr_addr;
        wr_data_nxt     = o_wr_data;
        frame_done_nxt  = 1'b0;
        frame_ok_nxt    = o_frame_ok;
        frame_count_nxt = o_frame_count;

        case (state)
            S_SYNC: begin
                if (r_vsync) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (vsync_fall && i_capture_en) begin
                    addr_nxt     = '0;
                    line_cnt_nxt = '0;
                    pix_cnt_nxt  = '0;
                    phase_nxt    = 1'b0;
                    line_err_nxt = 1'b0;
                    ovf_nxt      = 1'b0;
                    state_nxt    = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (vsync_rise) begin
                    frame_done_nxt  = 1'b1;
                    frame_ok_nxt    = !line_err && !ovf && (32'(line_cnt) == HEIGHT_IMAGE);
                    frame_count_nxt = o_frame_count + CNT_W'(1);
                    state_nxt       = S_WAIT;
                end else if (href_v) begin
                    phase_nxt = ~phase;
                    if (!phase) begin
                        hi_byte_nxt = r_data;
                    end else begin
                        if (32'(pix_cnt) <= WIDTH_IMAGE) pix_cnt_nxt = pix_cnt + PIX_W'(1);
                        if (32'(addr) < NUM_PIXELS) begin
                            wr_en_nxt   = 1'b1;
                            wr_addr_nxt = addr;
                            wr_data_nxt = {hi_byte, r_data};
                            addr_nxt    = addr + ADDR_W'(1);
                        end else begin
                            ovf_nxt = 1'b1;
                        end
                    end
                end else if (href_fall) begin
                    if (32'(line_cnt) <= HEIGHT_IMAGE) line_cnt_nxt = line_cnt + LINE_W'(1);
                    if ((32'(pix_cnt) != WIDTH_IMAGE) || phase) line_err_nxt = 1'b1;
                    phase_nxt   = 1'b0;
                    pix_cnt_nxt = '0;
                end
            end
            default: state_nxt = S_SYNC;
        endcase

        busy_nxt = (state_nxt == S_ACTIVE);
    end

endmodule

// File: tb/tb_cam_capture.sv
// Randomized scoreboard bench for cam_capture with a small 4x2 image.
module tb_cam_capture;

    localparam int unsigned W   = 4;
    localparam int unsigned H   = 2;
    localparam int unsigned NUM = W * H;

    logic        clk = 1'b0;
    logic        reset_n, capture_en, vsync, href;
    logic [7:0]  data;
    logic        o_wr_en, o_busy, o_frame_done, o_frame_ok;
    logic [18:0] o_wr_addr;
    logic [15:0] o_wr_data;
    logic [7:0]  o_frame_count;

    cam_capture #(.WIDTH_IMAGE(W), .HEIGHT_IMAGE(H)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_capture_en(capture_en),
        .i_vsync(vsync), .i_href(href), .i_data(data),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frame_ok(o_frame_ok),
        .o_frame_count(o_frame_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [18:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic ok; logic [7:0] cnt; } fd_t;
    wr_t wq[$];
    fd_t fq[$];
    int  n_tests = 0, n_fail = 0;
    int  mdl_count = 0, busy_seen = 0, vs_writes = 0;
    bit  busy_watch = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes / frame results whenever the DUT presents them.
    always @(negedge clk) begin
        if (reset_n) begin
            if (busy_watch && o_busy) busy_seen++;
            if (o_wr_en) begin
                if (vsync) vs_writes++;
                if (wq.size() == 0) begin
                    check("wr_expected", 32'(wq.size()), 32'd1);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", 32'(o_wr_addr), 32'(e.addr));
                    check("wr_data", 32'(o_wr_data), 32'(e.data));
                end
            end
            if (o_frame_done) begin
                if (fq.size() == 0) begin
                    check("done_expected", 32'(fq.size()), 32'd1);
                end else begin
                    fd_t f;
                    f = fq.pop_front();
                    check("frame_ok", 32'(o_frame_ok), 32'(f.ok));
                    check("frame_count", 32'(o_frame_count), 32'(f.cnt));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            href = 1'b0;
            data = 8'($urandom);
        end
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        href  = 1'b0;
        vsync = 1'b1;
        idle(3);
        vsync = 1'b0;
    endtask

    // Sends one frame; the reference result is computed from the byte stream itself.
    task automatic frame(input int lens[$], input bit seq, input bit drop_en);
        logic [7:0] b[$];
        int  addr, k;
        bit  captured, ok;
        wr_t w;
        fd_t f;
        captured = capture_en;
        vsync_pulse();
        if (!captured) begin
            busy_watch = 1;
            busy_seen  = 0;
        end
        idle(2);
        addr = 0;
        k    = 0;
        ok   = (lens.size() == H);
        foreach (lens[li]) begin
            b.delete();
            for (int j = 0; j < lens[li]; j++) begin
                b.push_back(seq ? 8'(k) : 8'($urandom));
                k++;
            end
            if (captured) begin
                if (lens[li] != int'(2 * W)) ok = 0;
                for (int p = 0; p < lens[li] / 2; p++) begin
                    if (addr < int'(NUM)) begin
                        w.addr = 19'(addr);
                        w.data = {b[2*p], b[2*p+1]};
                        wq.push_back(w);
                        addr++;
                    end else begin
                        ok = 0;
                    end
                end
            end
            foreach (b[j]) begin
                @(negedge clk);
                href = 1'b1;
                data = b[j];
                if (drop_en && li == 0 && j == lens[li] / 2) capture_en = 1'b0;
            end
            idle($urandom_range(1, 3));
        end
        if (captured) begin
            mdl_count++;
            f.ok  = ok;
            f.cnt = 8'(mdl_count);
            fq.push_back(f);
        end
        idle(2);
        if (!captured) begin
            busy_watch = 0;
            check("busy_idle_frame", 32'(busy_seen), 32'd0);
        end
    endtask

    initial begin
        int lens[$];
        reset_n = 1'b0; capture_en = 1'b1; vsync = 1'b0; href = 1'b0; data = 8'h00;
        #2;
        check("rst_wr_en", 32'(o_wr_en), 0);
        check("rst_wr_addr", 32'(o_wr_addr), 0);
        check("rst_wr_data", 32'(o_wr_data), 0);
        check("rst_busy_done_ok", {29'd0, o_busy, o_frame_done, o_frame_ok}, 0);
        check("rst_count", 32'(o_frame_count), 0);

        // Reset released mid-line with no VSYNC seen: nothing may be written.
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            href = 1'b1;
            data = 8'($urandom);
            if (j == 3) reset_n = 1'b1;
        end
        idle(3);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            href = 1'b1;
            data = 8'($urandom);
        end
        idle(4);
        check("busy_after_midframe_reset", 32'(o_busy), 0);

        lens = '{8, 8};    frame(lens, 1, 0);   // 0x0001..0x0E0F at addr 0..7
        lens = '{7, 8};    frame(lens, 0, 0);   // odd line: dangling byte dropped
        lens = '{8, 8, 8}; frame(lens, 0, 0);   // overflow
        lens = '{8, 8};    frame(lens, 0, 1);   // enable dropped mid-frame
        lens = '{8, 8};    frame(lens, 0, 0);   // not captured
        capture_en = 1'b1;
        lens = '{8, 8};    frame(lens, 0, 0);
        lens = '{8, 8};    frame(lens, 0, 0);

        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 5))
                0:       lens = '{8, 6};
                1:       lens = '{8};
                2:       lens = '{10, 8};
                3:       lens = '{8, 8, 2};
                default: lens = '{8, 8};
            endcase
            frame(lens, 0, 0);
        end
        vsync_pulse();
        idle(10);
        check("wq_drained", 32'(wq.size()), 0);
        check("fq_drained", 32'(fq.size()), 0);
        check("count_model", 32'(o_frame_count), 32'(8'(mdl_count)));

        // Asynchronous reset clears outputs without a clock edge.
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_count", 32'(o_frame_count), 0);
        check("async_rst_ok_busy", {30'd0, o_frame_ok, o_busy}, 0);
        mdl_count = 0;
        @(negedge clk);
        reset_n = 1'b1;
        lens = '{8, 8}; frame(lens, 0, 0);
        vsync_pulse();
        idle(10);
        check("wq_drained_final", 32'(wq.size()), 0);
        check("fq_drained_final", 32'(fq.size()), 0);
        check("count_after_reset", 32'(o_frame_count), 1);
        check("writes_during_vsync", 32'(vs_writes), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
